mc_row_burst_splitter: RTL and testbench
========================================

# mc_row_burst_splitter

Parametrised command splitter between the memory controller's AXI address front end and its array scheduler. It accepts one burst command at a time (address plus length) and emits a sequence of sub-commands. Each sub-command stays inside a single array row and never exceeds a programmable maximum beat count. It generalises the controller's fixed cross-row handling to arbitrary row/column split, a sub-burst cap, a row wrap and an issue-hold input.

## Interface
- AXI_ADDR_WIDTH, 20, burst byte/beat address width
- AXI_LEN_WIDTH, 6, burst length field width (beats = len+1)
- AXI_RADDR_WIDTH, 14, row address width (upper address bits)
- AXI_CADDR_WIDTH, AXI_ADDR_WIDTH-AXI_RADDR_WIDTH, column width (lower bits); derived, not overridden
- MAX_SUB_BEATS, 64, maximum beats per sub-command; legal range ≥1

Ports:
- clk  in  1  controller clock
- rst_n  in  1  reset; synchronous, active-low, sampled on rising clk
- cmd_valid  in  1  burst command valid
- cmd_ready  out  1  splitter can accept a command
- cmd_wr  in  1  direction tag (1 = write), passed through unchanged
- cmd_addr  in  AXI_ADDR_WIDTH  start address {row, col}
- cmd_len  in  AXI_LEN_WIDTH  beats-1
- hold  in  1  blocks issue of a new sub-command (refresh/arbitration stall)
- sub_valid  out  1  sub-command valid
- sub_ready  in  1  scheduler accepts sub-command
- sub_wr  out  1  direction tag
- sub_raddr  out  AXI_RADDR_WIDTH  row
- sub_caddr  out  AXI_CADDR_WIDTH  start column
- sub_len  out  AXI_LEN_WIDTH  sub-burst beats-1
- sub_first  out  1  first sub-command of the burst
- sub_last  out  1  last sub-command of the burst
- busy  out  1  command in progress (state ≠ IDLE)

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch the following, then go to ISSUE:
  - row = addr[ADDR-1:CADDR], col = addr[CADDR-1:0]
  - rem = cmd_len+1 (AXI_LEN_WIDTH+1 bits)
  - wr, and first flag set to 1
- ISSUE: compute room = 2^CADDR − col (CADDR+1 bits) and chunk = min(rem, room, MAX_SUB_BEATS).
  - hold=0: register sub_raddr=row, sub_caddr=col, sub_len=chunk−1, sub_wr=wr, sub_first=first, sub_last=(chunk==rem), sub_valid=1; go to WAIT.
  - hold=1: stay in ISSUE with sub_valid=0.
- WAIT: sub_valid and all sub_* fields are held stable until sub_ready. hold has no effect on an already-asserted sub_valid.
- On sub_valid&&sub_ready:
  - sub_valid←0, first←0, rem←rem−chunk
  - col←(col+chunk) mod 2^CADDR
  - if col+chunk==2^CADDR, row←row+1; row 2^RADDR−1 wraps to 0
  - go to IDLE if sub_last, else to ISSUE
- cmd_valid while busy is ignored (cmd_ready=0). No command is queued.
- Single-chunk burst: sub_first=sub_last=1.

## Timing
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; sub_valid, sub_first, sub_last, sub_wr, busy all 0; sub_raddr, sub_caddr, sub_len all 0.
  - cmd_ready=0 while rst_n=0 and 1 from the first cycle after release.
  - Reset mid-burst discards the command and any pending sub-command with no further sub_valid.
- Command accepted at edge k: sub_valid=1 after edge k+1 if hold=0 in cycle k..k+1.
- Sub-command accepted at edge j: next sub_valid after edge j+1 (one bubble cycle). A final accept at edge j gives cmd_ready=1 after edge j.
- Minimum command-to-command spacing: 3 cycles per single-chunk burst with sub_ready held high.
- All outputs are registered or decoded directly from the state register; there is no combinational path from cmd_* or sub_ready to outputs.

## Test plan
- Non-crossing: addr={14'd100,6'd50}, len=4, hold=0, sub_ready=1 → one sub-command row 100, col 50, len 4, first=last=1; sub_valid 2 edges after accept; cmd_ready high again next cycle.
- Row cross: addr={14'd100,6'd63}, len=4 → (row100, col63, len0, first) then (row101, col0, len3, last).
- Cap split: MAX_SUB_BEATS=4, addr={14'd7,6'd0}, len=9 → (7,0,3,first), (7,4,3), (7,8,1,last).
- Row wrap: addr={14'h3FFF,6'd62}, len=3 → (16383,62,1,first), (0,0,1,last).
- Handshake/hold:
  - sub_ready=0 for 5 cycles → fields stable throughout.
  - hold=1 raised while sub_valid=1 → sub_valid stays 1.
  - hold=1 in ISSUE for 3 cycles → no sub_valid until hold drops.
  - cmd_valid asserted while busy → no acceptance.
- Reset mid-op: assert rst_n=0 in WAIT of a 2-chunk burst → next edge sub_valid=0, busy=0; after release no residual sub-commands; a fresh command is processed normally.

Source files
------------

// File: rtl/mc_row_burst_splitter.sv
// mc_row_burst_splitter: splits AXI bursts into row-bounded, length-capped sub-commands
module mc_row_burst_splitter #(
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int AXI_LEN_WIDTH = 6,
  parameter int AXI_RADDR_WIDTH = 14,
  localparam int AXI_CADDR_WIDTH = AXI_ADDR_WIDTH - AXI_RADDR_WIDTH,
  parameter int MAX_SUB_BEATS = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_wr,
  input  logic [AXI_ADDR_WIDTH-1:0]  cmd_addr,
  input  logic [AXI_LEN_WIDTH-1:0]   cmd_len,
  input  logic                       hold,
  output logic                       sub_valid,
  input  logic                       sub_ready,
  output logic                       sub_wr,
  output logic [AXI_RADDR_WIDTH-1:0] sub_raddr,
  output logic [AXI_CADDR_WIDTH-1:0] sub_caddr,
  output logic [AXI_LEN_WIDTH-1:0]   sub_len,
  output logic                       sub_first,
  output logic                       sub_last,
  output logic                       busy
);
  localparam int CW = AXI_CADDR_WIDTH;
  localparam int RW = AXI_RADDR_WIDTH;
  localparam int LW = AXI_LEN_WIDTH;
  localparam int RMW = LW + 1;
  localparam int NW = (LW > CW ? LW : CW) + 1;
  localparam logic [NW-1:0] CAP = (MAX_SUB_BEATS >= (1 << NW) - 1) ? '1 : NW'(MAX_SUB_BEATS);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state_q, state_d;
  logic [RW-1:0] row_q, row_d, sub_raddr_q, sub_raddr_d;
  logic [CW-1:0] col_q, col_d, sub_caddr_q, sub_caddr_d;
  logic [RMW-1:0] rem_q, rem_d;
  logic [NW-1:0] chunk_q, chunk_d, rem_w, room, chunk;
  logic [CW:0] col_sum;
  logic [LW-1:0] sub_len_q, sub_len_d;
  logic wr_q, wr_d, first_q, first_d;
  logic sub_valid_q, sub_valid_d, sub_wr_q, sub_wr_d;
  logic sub_first_q, sub_first_d, sub_last_q, sub_last_d;
  logic cmd_ready_q, cmd_ready_d;
  // chunk size for the next sub-command and column advance for the pending one
  always_comb begin
    rem_w = NW'(rem_q);
    room = (NW'(1) << CW) - NW'(col_q);
    chunk = rem_w < room ? rem_w : room;
    chunk = chunk < CAP ? chunk : CAP;
    col_sum = {1'b0, col_q} + chunk_q[CW:0];
  end
  // next-state and next-output computation for the IDLE/ISSUE/WAIT sequencer
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    col_d = col_q;
    rem_d = rem_q;
    wr_d = wr_q;
    first_d = first_q;
    chunk_d = chunk_q;
    sub_valid_d = sub_valid_q;
    sub_wr_d = sub_wr_q;
    sub_raddr_d = sub_raddr_q;
    sub_caddr_d = sub_caddr_q;
    sub_len_d = sub_len_q;
    sub_first_d = sub_first_q;
    sub_last_d = sub_last_q;
    if (state_q == IDLE && cmd_valid) begin
      state_d = ISSUE;
      row_d = cmd_addr[AXI_ADDR_WIDTH-1:CW];
      col_d = cmd_addr[CW-1:0];
      rem_d = RMW'(cmd_len) + RMW'(1);
      wr_d = cmd_wr;
      first_d = 1'b1;
    end else if (state_q == ISSUE && !hold) begin
      state_d = WAIT;
      chunk_d = chunk;
      sub_valid_d = 1'b1;
      sub_wr_d = wr_q;
      sub_raddr_d = row_q;
      sub_caddr_d = col_q;
      sub_len_d = LW'(chunk - NW'(1));
      sub_first_d = first_q;
      sub_last_d = chunk == rem_w;
    end else if (state_q == WAIT && sub_ready) begin
      state_d = sub_last_q ? IDLE : ISSUE;
      sub_valid_d = 1'b0;
      first_d = 1'b0;
      rem_d = rem_q - RMW'(chunk_q);
      col_d = col_sum[CW-1:0];
      row_d = row_q + RW'(col_sum[CW]);
    end
    cmd_ready_d = state_d == IDLE;
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q <= '0;
      col_q <= '0;
      rem_q <= '0;
      wr_q <= 1'b0;
      first_q <= 1'b0;
      chunk_q <= '0;
      sub_valid_q <= 1'b0;
      sub_wr_q <= 1'b0;
      sub_raddr_q <= '0;
      sub_caddr_q <= '0;
      sub_len_q <= '0;
      sub_first_q <= 1'b0;
      sub_last_q <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      col_q <= col_d;
      rem_q <= rem_d;
      wr_q <= wr_d;
      first_q <= first_d;
      chunk_q <= chunk_d;
      sub_valid_q <= sub_valid_d;
      sub_wr_q <= sub_wr_d;
      sub_raddr_q <= sub_raddr_d;
      sub_caddr_q <= sub_caddr_d;
      sub_len_q <= sub_len_d;
      sub_first_q <= sub_first_d;
      sub_last_q <= sub_last_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end
  assign cmd_ready = cmd_ready_q;
  assign sub_valid = sub_valid_q;
  assign sub_wr = sub_wr_q;
  assign sub_raddr = sub_raddr_q;
  assign sub_caddr = sub_caddr_q;
  assign sub_len = sub_len_q;
  assign sub_first = sub_first_q;
  assign sub_last = sub_last_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_mc_row_burst_splitter.sv
// tb_mc_row_burst_splitter: directed and randomized checks of the burst splitter against a beat-level model
module tb_mc_row_burst_splitter;
  typedef struct packed {
    logic wr;
    logic [13:0] r;
    logic [5:0] c;
    logic [5:0] l;
    logic f;
    logic la;
  } sub_t;
  logic clk = 0, rst_n = 0, cmd_valid = 0, cmd_wr = 0, hold = 0, sub_ready = 0;
  logic [19:0] cmd_addr = '0;
  logic [5:0] cmd_len = '0;
  logic [1:0] cmd_ready, sub_valid, sub_wr, sub_first, sub_last, busy;
  logic [13:0] raddr [2];
  logic [5:0] caddr [2];
  logic [5:0] slen [2];
  int sel = 0, checks = 0, errors = 0;
  sub_t exp_q[$];

  always #5 clk = ~clk;

  mc_row_burst_splitter u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .hold(hold), .sub_valid(sub_valid[0]), .sub_ready(sub_ready),
    .sub_wr(sub_wr[0]), .sub_raddr(raddr[0]), .sub_caddr(caddr[0]), .sub_len(slen[0]),
    .sub_first(sub_first[0]), .sub_last(sub_last[0]), .busy(busy[0]));

  mc_row_burst_splitter #(.MAX_SUB_BEATS(4)) u_cap (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .hold(hold), .sub_valid(sub_valid[1]), .sub_ready(sub_ready),
    .sub_wr(sub_wr[1]), .sub_raddr(raddr[1]), .sub_caddr(caddr[1]), .sub_len(slen[1]),
    .sub_first(sub_first[1]), .sub_last(sub_last[1]), .busy(busy[1]));

  function automatic sub_t obs();
    return {sub_wr[sel], raddr[sel], caddr[sel], slen[sel], sub_first[sel], sub_last[sel]};
  endfunction

  // walk the burst beat by beat in flat address space: each piece ends at a row end, the cap or the burst end
  function automatic void build(input logic [19:0] addr, input int len, input int mx, input logic wr);
    int beats = len + 1;
    int a = int'(addr);
    bit first = 1;
    exp_q.delete();
    while (beats > 0) begin
      int col = a % 64;
      int ch = beats < 64 - col ? beats : 64 - col;
      if (ch > mx) ch = mx;
      exp_q.push_back({wr, 14'(a / 64), 6'(col), 6'(ch - 1), first, ch == beats});
      first = 0;
      beats -= ch;
      a = (a + ch) % (1 << 20);
    end
  endfunction

  task automatic pulse_reset();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic run_burst(input logic [19:0] addr, input int len, input logic wr, input int mx,
                           input int rdy_pct, input int hold_pct, input string nm);
    sub_t prev = '0;
    bit pv = 0;
    int cyc = 0;
    build(addr, len, mx, wr);
    checks++;
    if (cmd_ready[sel] !== 1'b1) begin errors++; $display("FAIL %s ready_at_start got %b exp 1", nm, cmd_ready[sel]); end
    cmd_valid = 1; cmd_addr = addr; cmd_len = len[5:0]; cmd_wr = wr;
    @(negedge clk);
    cmd_valid = 0;
    while (exp_q.size() > 0 && cyc < 500) begin
      cyc++;
      hold = $urandom_range(99) < hold_pct;
      if (sub_valid[sel]) begin
        if (pv) begin
          checks++;
          if (obs() !== prev) begin errors++; $display("FAIL %s stable got %h exp %h", nm, obs(), prev); end
        end
        sub_ready = $urandom_range(99) < rdy_pct;
        if (sub_ready) begin
          checks++;
          if (obs() !== exp_q[0]) begin errors++; $display("FAIL %s sub got %h exp %h", nm, obs(), exp_q[0]); end
          void'(exp_q.pop_front());
          pv = 0;
        end else begin
          pv = 1;
          prev = obs();
        end
      end else begin
        sub_ready = 1'($urandom_range(1));
        pv = 0;
      end
      @(negedge clk);
    end
    sub_ready = 0; hold = 0;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL %s timeout got %0d pending exp 0", nm, exp_q.size()); end
    checks++;
    if ({cmd_ready[sel], busy[sel], sub_valid[sel]} !== 3'b100) begin
      errors++; $display("FAIL %s end ready/busy/valid got %b exp 100", nm, {cmd_ready[sel], busy[sel], sub_valid[sel]});
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({cmd_ready[0], sub_valid[0], busy[0], sub_wr[0], sub_first[0], sub_last[0]} !== 6'b0) begin
      errors++; $display("FAIL reset flags got %b exp 000000", {cmd_ready[0], sub_valid[0], busy[0], sub_wr[0], sub_first[0], sub_last[0]});
    end
    checks++;
    if ({raddr[0], caddr[0], slen[0]} !== 26'b0) begin errors++; $display("FAIL reset fields got %h exp 0", {raddr[0], caddr[0], slen[0]}); end
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (cmd_ready[0] !== 1'b1) begin errors++; $display("FAIL reset_release ready got %b exp 1", cmd_ready[0]); end
  endtask

  task automatic test_non_crossing();
    build({14'd100, 6'd50}, 4, 64, 1'b0);
    cmd_valid = 1; cmd_addr = {14'd100, 6'd50}; cmd_len = 6'd4; cmd_wr = 0;
    @(negedge clk);
    cmd_valid = 0;
    checks++;
    if ({sub_valid[0], busy[0], cmd_ready[0]} !== 3'b010) begin
      errors++; $display("FAIL nc_issue valid/busy/ready got %b exp 010", {sub_valid[0], busy[0], cmd_ready[0]});
    end
    @(negedge clk);
    checks++;
    if (sub_valid[0] !== 1'b1) begin errors++; $display("FAIL nc_latency valid got %b exp 1", sub_valid[0]); end
    checks++;
    if (obs() !== exp_q[0]) begin errors++; $display("FAIL nc_sub got %h exp %h", obs(), exp_q[0]); end
    sub_ready = 1;
    @(negedge clk);
    sub_ready = 0;
    checks++;
    if ({sub_valid[0], busy[0], cmd_ready[0]} !== 3'b001) begin
      errors++; $display("FAIL nc_done valid/busy/ready got %b exp 001", {sub_valid[0], busy[0], cmd_ready[0]});
    end
  endtask

  task automatic test_stall_hold();
    build({14'd200, 6'd60}, 20, 64, 1'b1);
    cmd_valid = 1; cmd_addr = {14'd200, 6'd60}; cmd_len = 6'd20; cmd_wr = 1;
    @(negedge clk);
    cmd_valid = 0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1; cmd_addr = 20'h12345; cmd_len = 6'd1;
      hold = i >= 2;
      @(negedge clk);
      checks++;
      if (sub_valid[0] !== 1'b1 || obs() !== exp_q[0]) begin
        errors++; $display("FAIL stall_%0d got v=%b %h exp v=1 %h", i, sub_valid[0], obs(), exp_q[0]);
      end
      checks++;
      if (cmd_ready[0] !== 1'b0) begin errors++; $display("FAIL busy_ignore_%0d ready got %b exp 0", i, cmd_ready[0]); end
    end
    cmd_valid = 0; hold = 0; sub_ready = 1;
    @(negedge clk);
    sub_ready = 0; hold = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (sub_valid[0] !== 1'b0) begin errors++; $display("FAIL hold_issue_%0d valid got %b exp 0", i, sub_valid[0]); end
    end
    hold = 0;
    @(negedge clk);
    checks++;
    if (sub_valid[0] !== 1'b1 || obs() !== exp_q[1]) begin
      errors++; $display("FAIL hold_release got v=%b %h exp v=1 %h", sub_valid[0], obs(), exp_q[1]);
    end
    sub_ready = 1;
    @(negedge clk);
    sub_ready = 0;
    checks++;
    if ({sub_valid[0], busy[0], cmd_ready[0]} !== 3'b001) begin
      errors++; $display("FAIL stall_done valid/busy/ready got %b exp 001", {sub_valid[0], busy[0], cmd_ready[0]});
    end
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1; cmd_addr = {14'd100, 6'd63}; cmd_len = 6'd4; cmd_wr = 0;
    @(negedge clk);
    cmd_valid = 0;
    @(negedge clk);
    checks++;
    if (sub_valid[0] !== 1'b1) begin errors++; $display("FAIL rm_wait valid got %b exp 1", sub_valid[0]); end
    rst_n = 0;
    @(negedge clk);
    checks++;
    if ({sub_valid[0], busy[0], cmd_ready[0]} !== 3'b000) begin
      errors++; $display("FAIL rm_reset valid/busy/ready got %b exp 000", {sub_valid[0], busy[0], cmd_ready[0]});
    end
    rst_n = 1; sub_ready = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (sub_valid[0] !== 1'b0) begin errors++; $display("FAIL rm_residual_%0d valid got %b exp 0", i, sub_valid[0]); end
    end
    sub_ready = 0;
    run_burst({14'd9, 6'd60}, 7, 1'b1, 64, 100, 0, "rm_fresh");
  endtask

  task automatic test_random(input int n, input int mx, input string nm);
    for (int i = 0; i < n; i++) begin
      logic [19:0] a = 20'($urandom);
      if ($urandom_range(1) == 1) a[5:0] = 6'(64 - $urandom_range(1, 8));
      run_burst(a, $urandom_range(63), 1'($urandom_range(1)), mx, $urandom_range(30, 100), $urandom_range(0, 50), nm);
    end
  endtask

  initial begin
    test_reset();
    test_non_crossing();
    run_burst({14'd100, 6'd63}, 4, 1'b1, 64, 100, 0, "row_cross");
    run_burst({14'h3FFF, 6'd62}, 3, 1'b0, 64, 100, 0, "row_wrap");
    test_stall_hold();
    test_reset_mid();
    test_random(40, 64, "rand64");
    sel = 1;
    pulse_reset();
    run_burst({14'd7, 6'd0}, 9, 1'b0, 4, 100, 0, "cap_split");
    test_random(15, 4, "rand_cap");
    sel = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
